// File: rtl/sample_packer_pkg.sv
// Shared constants and state type for the sample packer and its unpacker counterpart.
package sample_pkg;

  localparam int SAMPLE_WIDTH = 3;
  localparam int WORD_WIDTH   = 16;
  localparam int ACC_WIDTH    = 18;
  localparam int COUNT_WIDTH  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } packer_state_e;

endpackage

// File: rtl/sample_packer_if.sv
// Sample-side and FIFO-side signals of the packer; slave modport is the packer itself.
interface sample_packer_if;
  import sample_pkg::*;

  logic                    enable;
  logic                    sample_valid;
  logic [SAMPLE_WIDTH-1:0] sample_data;
  logic                    flush;
  logic                    packet_full;
  logic                    packet_write;
  logic [WORD_WIDTH-1:0]   packet_data;

  modport master (
    output enable, sample_valid, sample_data, flush, packet_full,
    input  packet_write, packet_data
  );

  modport slave (
    input  enable, sample_valid, sample_data, flush, packet_full,
    output packet_write, packet_data
  );

endinterface

// File: rtl/sample_packer_sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sample_packer.sv
// Packs a continuous LSB-first stream of 3-bit samples into 16-bit FIFO words.
// Define SAMPLE_PACKER_STATS_EN to implement the wrapping total_sample_count.
module sample_packer
  import sample_pkg::*;
(
  input  logic              clk_sample,
  input  logic              reset_n,
  sample_packer_if.slave    bus,
  output logic              overflow,
  output logic [15:0]       overflow_count,
  output logic [31:0]       total_sample_count
);

  packer_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d, acc_base, acc_sum;
  logic [COUNT_WIDTH-1:0]  bit_count_q, bit_count_d, count_base, count_sum;
  logic                    packet_write_q, packet_write_d;
  logic [WORD_WIDTH-1:0]   packet_data_q, packet_data_d;
  logic                    overflow_q, overflow_d;
  logic                    accept, word_done, flush_fire, emit, drop;

  always_comb begin
    state_d    = bus.enable ? RUN : IDLE;
    accept     = bus.enable && bus.sample_valid;
    acc_base   = (state_q == RUN) ? acc_q : '0;
    count_base = (state_q == RUN) ? bit_count_q : '0;

    acc_sum   = acc_base;
    count_sum = count_base;
    if (accept) begin
      acc_sum   = acc_base | (ACC_WIDTH'(bus.sample_data) << count_base);
      count_sum = count_base + COUNT_WIDTH'(SAMPLE_WIDTH);
    end

    // Flush is judged on the post-sample count, so a flush that lands on a
    // completing sample emits that word and drops the residual bits.
    word_done  = (count_sum >= COUNT_WIDTH'(WORD_WIDTH));
    flush_fire = bus.enable && bus.flush && (count_sum != '0);
    emit       = word_done || flush_fire;
    drop       = emit && bus.packet_full;

    acc_d       = acc_sum;
    bit_count_d = count_sum;
    if (!bus.enable || flush_fire) begin
      acc_d       = '0;
      bit_count_d = '0;
    end else if (word_done) begin
      acc_d       = acc_sum >> WORD_WIDTH;
      bit_count_d = count_sum - COUNT_WIDTH'(WORD_WIDTH);
    end

    packet_write_d = emit && !bus.packet_full;
    packet_data_d  = packet_write_d ? acc_sum[WORD_WIDTH-1:0] : packet_data_q;
    overflow_d     = overflow_q || drop;
  end

  always_ff @(posedge clk_sample) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      bit_count_q    <= '0;
      packet_write_q <= 1'b0;
      packet_data_q  <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      bit_count_q    <= bit_count_d;
      packet_write_q <= packet_write_d;
      packet_data_q  <= packet_data_d;
      overflow_q     <= overflow_d;
    end
  end

  sat_counter16 u_overflow_count (
    .clk     (clk_sample),
    .reset_n (reset_n),
    .inc     (drop),
    .count   (overflow_count)
  );

`ifdef SAMPLE_PACKER_STATS_EN
  logic [31:0] total_q, total_d;

  always_comb begin
    total_d = accept ? (total_q + 32'd1) : total_q;
  end

  always_ff @(posedge clk_sample) begin
    if (!reset_n) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign total_sample_count = total_q;
`else
  assign total_sample_count = 32'd0;
`endif

  assign bus.packet_write = packet_write_q;
  assign bus.packet_data  = packet_data_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_sample_packer.sv
// Directed self-checking bench for sample_packer; expected words are hand-computed.
module tb_sample_packer;

  logic        clk;
  logic        reset_n;
  logic        overflow;
  logic [15:0] overflow_count;
  logic [31:0] total_sample_count;
  int          checks;
  int          errors;

  sample_packer_if pif ();

  sample_packer dut (
    .clk_sample         (clk),
    .reset_n            (reset_n),
    .bus                (pif.slave),
    .overflow           (overflow),
    .overflow_count     (overflow_count),
    .total_sample_count (total_sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic en, input logic valid, input logic [2:0] data,
                               input logic fl, input logic full);
    pif.enable       = en;
    pif.sample_valid = valid;
    pif.sample_data  = data;
    pif.flush        = fl;
    pif.packet_full  = full;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic expectWrite(input string tag, input logic exp_write, input logic [15:0] exp_data);
    checkOutput({tag, "_write"}, {31'd0, pif.packet_write}, {31'd0, exp_write});
    if (exp_write) begin
      checkOutput({tag, "_data"}, {16'd0, pif.packet_data}, {16'd0, exp_data});
    end
  endtask

  initial begin
    logic        exp_w;
    logic [15:0] exp_d;
    checks = 0;
    errors = 0;

    // Reset with an enabled valid sample present; it must not enter the stream.
    reset_n          = 1'b0;
    pif.enable       = 1'b1;
    pif.sample_valid = 1'b1;
    pif.sample_data  = 3'b001;
    pif.flush        = 1'b0;
    pif.packet_full  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    checkOutput("rst_write", {31'd0, pif.packet_write}, 32'd0);
    checkOutput("rst_data", {16'd0, pif.packet_data}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("rst_ovf_count", {16'd0, overflow_count}, 32'd0);
    checkOutput("rst_total", total_sample_count, 32'd0);

    applyStimulus(1, 0, 3'b000, 1, 0);
    expectWrite("flush_empty", 1'b0, 16'h0);

    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1, 1, 3'b001, 0, 0);
      exp_w = (i == 6) || (i == 11) || (i == 16);
      exp_d = (i == 6) ? 16'h9249 : (i == 11) ? 16'h4924 : 16'h2492;
      expectWrite($sformatf("ones001_s%0d", i), exp_w, exp_d);
    end

    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1, 1, 3'b111, 0, 0);
      exp_w = (i == 6) || (i == 11) || (i == 16);
      expectWrite($sformatf("all111_s%0d", i), exp_w, 16'hFFFF);
    end

    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1, 1, 3'b111, 0, 0);
      expectWrite($sformatf("pre_flush_s%0d", i), (i == 6), 16'hFFFF);
    end
    applyStimulus(1, 0, 3'b000, 1, 0);
    expectWrite("flush_partial", 1'b1, 16'h001F);

    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1, 1, 3'b111, 0, (i <= 6));
      exp_w = (i == 11) || (i == 16);
      expectWrite($sformatf("full_s%0d", i), exp_w, 16'hFFFF);
      if (i == 6) begin
        checkOutput("full_overflow", {31'd0, overflow}, 32'd1);
        checkOutput("full_ovf_count", {16'd0, overflow_count}, 32'd1);
      end
    end

    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 1, 3'b111, 0, 0);
    end
    applyStimulus(1, 1, 3'b111, 1, 0);
    expectWrite("flush_on_word", 1'b1, 16'hFFFF);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1, 1, 3'b001, 0, 0);
      expectWrite($sformatf("after_flush_word_s%0d", i), (i == 6), 16'h9249);
    end

    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1, 1, 3'b111, 0, 0);
    end
    applyStimulus(0, 1, 3'b111, 0, 0);
    expectWrite("disabled", 1'b0, 16'h0);
    checkOutput("ovf_held", {31'd0, overflow}, 32'd1);
    checkOutput("ovf_count_held", {16'd0, overflow_count}, 32'd1);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1, 1, 3'b001, 0, 0);
      expectWrite($sformatf("after_disable_s%0d", i), (i == 6), 16'h9249);
    end

    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, 1, 3'b111, 0, 0);
    end
    reset_n = 1'b0;
    applyStimulus(1, 0, 3'b000, 0, 0);
    reset_n = 1'b1;
    checkOutput("midrst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("midrst_ovf_count", {16'd0, overflow_count}, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1, 1, 3'b001, 0, 0);
      expectWrite($sformatf("after_reset_s%0d", i), (i == 6), 16'h9249);
    end

    reset_n = 1'b0;
    applyStimulus(0, 0, 3'b000, 0, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(!((i >= 40) && (i < 50)), 1, 3'b101, 0, 0);
    end
`ifdef SAMPLE_PACKER_STATS_EN
    checkOutput("total_samples", total_sample_count, 32'd90);
`else
    checkOutput("total_samples", total_sample_count, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_packer.md
# sample_packer

Packs a real-time stream of 3-bit sign/magnitude samples into 16-bit words and writes them into the packet data FIFO. It is the transmit-side counterpart of the sample unpacker that feeds the correlators: it sits between the RF front-end sample capture and the packet FIFO. Samples form a continuous LSB-first bitstream with no padding, so words carry 5 or 6 samples and samples may straddle word boundaries.

## Interface
- No parameters. Word width 16 and sample width 3 are fixed constants.
- clk_sample  input  1  sample clock; all logic on its rising edge.
- reset_n  input  1  synchronous reset, active-low.
- enable  input  1  packing enable. Low: samples ignored, partial bits discarded.
- sample_valid  input  1  sample_data holds a valid sample this cycle. No back-pressure.
- sample_data  input  3  sample bits; bit 0 enters the stream first.
- flush  input  1  single-cycle request to zero-pad and emit any partial word.
- packet_full  input  1  FIFO full.
- packet_write  output  1  registered FIFO write strobe.
- packet_data  output  16  registered FIFO write data.
- overflow  output  1  sticky: a word was dropped because the FIFO was full.
- overflow_count  output  16  dropped-word count, saturating at 16'hFFFF.
- total_sample_count  output  32  accepted samples, wrapping (only with SAMPLE_PACKER_STATS_EN).

## Operation
- Accumulator acc[17:0] and bit count bit_count[4:0] in the range 0..15 between cycles.
- Accepted sample (enable && sample_valid): acc |= sample_data << bit_count; bit_count += 3.
- If the new count is at least 16: form word = acc[15:0], acc = acc >> 16, bit_count -= 16. The residual is 0, 1 or 2 bits.
- Word cycle repeats every 16 samples = 3 words. Words complete after samples 6, 11 and 16 of each cycle.
- Flush (enable && flush && bit_count>0, evaluated after any sample accepted in the same cycle): emit acc[15:0] with unfilled bits zero, then clear acc and bit_count.
  - A flush with bit_count==0 does nothing.
  - If a sample in the same cycle completes a word, the full word is emitted, the residual is dropped, and state clears.
- Emit when packet_full is low: packet_write=1 and packet_data=word on the next cycle.
- Emit when packet_full is high: the word is dropped, overflow is set, overflow_count is incremented. The accumulator continues, so stream alignment is preserved.
- enable low: acc and bit_count are cleared every cycle and no writes occur. Stats and overflow are held.
- States:
  - IDLE: enable low.
  - RUN: enable high.
  - Transitions follow enable only. Flush needs no state; it is handled combinationally in RUN.

## Timing
- Latency: packet_write is asserted exactly one cycle after the edge that accepted the completing sample or flush. It is high for one cycle.
- packet_full is sampled in the same cycle as the completing sample.
- Writes are at least 5 cycles apart under continuous samples, except a flush 1 cycle after a word completes.
- Reset values: packet_write=0, packet_data=16'h0, overflow=0, overflow_count=0, total_sample_count=0, acc=0, bit_count=0.
- Reset mid-word discards the partial word. The first sample after reset starts at bit 0.
- A sample_valid pulse in the reset cycle is ignored.

## Configuration
- SAMPLE_PACKER_STATS_EN defined: total_sample_count is implemented. It increments on every accepted sample and wraps at 2^32.
- SAMPLE_PACKER_STATS_EN undefined: the counter is removed and the port is tied to 32'd0.
- overflow and overflow_count are present in both builds.

## Structure
- Shared package `sample_pkg` holds:
  - SAMPLE_WIDTH=3 and WORD_WIDTH=16 constants.
  - The ACC_WIDTH=18 constant.
  - The IDLE/RUN state typedef.
  - The same constants are reused by the unpacker.
- One natural sub-module, `sat_counter16`, for overflow_count.
- Accumulator, emit and flush logic stay in the top-level block.

## Test plan
- Reset, then enable and 16 samples of 3'b111 back-to-back -> three writes of 16'hFFFF, one cycle after samples 6, 11 and 16.
- 16 samples of 3'b001 -> writes 16'h9249, 16'h4924, 16'h2492 in order; bit_count ends at 0.
- 7 samples of 3'b111, then flush -> writes 16'hFFFF, then 16'h001F one cycle after flush.
- packet_full high throughout samples 1-6 of 3'b111, low afterwards, then 10 more samples -> first word dropped, overflow=1, overflow_count=1, next writes 16'hFFFF ×2.
- reset_n low for one cycle after 4 samples, then 6 samples of 3'b001 -> single write 16'h9249, with no residue from before reset.
- STATS build, 100 samples with enable dropped for 10 of them -> total_sample_count=90; non-STATS build reads 0.
